ram_programmer: RTL and testbench
=================================

// Module: ram_programmer
// PURPOSE
//   Initiator-side controller for the 16-byte DFF program RAM. Loads a full program
//   image into RAM from a byte stream (valid/ready), and dumps RAM contents back out
//   as a byte stream. Drives RAM address/data/lr_n/ce_n; sits between the external
//   programming port and the RAM before the CPU is released from reset.
// PARAMETERS
//   RAM_BYTES  16  number of RAM locations loaded/dumped (must equal 2**ADDR_BITS)
//   ADDR_BITS  4   RAM address width
// PORTS
//   clk         in   1          rising-edge clock, shared with the RAM
//   rst         in   1          synchronous, active-high reset
//   start_load  in   1          pulse: begin load of RAM_BYTES bytes (ignored when busy)
//   start_dump  in   1          pulse: begin dump of RAM_BYTES bytes (ignored when busy)
//   in_valid    in   1          load byte available
//   in_data     in   8          load byte
//   in_ready    out  1          controller accepts in_data this cycle
//   out_valid   out  1          dump byte available
//   out_data    out  8          dump byte
//   out_ready   in   1          consumer accepts out_data this cycle
//   ram_addr    out  ADDR_BITS  to RAM address input
//   ram_wdata   out  8          to RAM data input
//   ram_rdata   in   8          from RAM registered data output
//   ram_lr_n    out  1          to RAM load (write) strobe, active-low
//   ram_ce_n    out  1          to RAM chip enable (read), active-low
//   busy        out  1          high in any state other than IDLE
//   done        out  1          one-cycle pulse when a load or dump completes
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, ram_addr=0, ram_wdata=0, ram_lr_n=1,
//     ram_ce_n=1, in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
//   - Reset mid-operation aborts immediately to IDLE; RAM keeps partially written data.
//   - RAM timing: write occurs at the edge ending a cycle with ram_lr_n=0; with
//     ram_ce_n=0 and ram_lr_n=1, ram_rdata is valid the cycle after.
//   - ram_lr_n and ram_ce_n are never both low. Each is low for exactly one cycle per access.
//   - States: IDLE, LOAD, WRITE, RD_REQ, RD_WAIT, RD_CAP, DUMP.
//   - IDLE: start_load -> LOAD (addr=0); else start_dump -> RD_REQ (addr=0).
//     Both asserted same cycle: load wins, dump request dropped.
//   - LOAD: in_ready=1. On in_valid&&in_ready: ram_wdata<=in_data, ram_addr<=addr,
//     ram_lr_n<=0 -> WRITE. Stays in LOAD while in_valid=0 (no timeout).
//   - WRITE: in_ready=0, ram_lr_n=0 for this cycle. If addr==RAM_BYTES-1: -> IDLE,
//     done=1, addr wraps to 0. Else addr<=addr+1 -> LOAD. Throughput 1 byte / 2 cycles.
//   - RD_REQ: ram_addr=addr, ram_ce_n=0 for this cycle -> RD_WAIT.
//   - RD_WAIT: ram_ce_n=1; RAM data_out updating -> RD_CAP.
//   - RD_CAP: out_data<=ram_rdata, out_valid<=1 -> DUMP.
//   - DUMP: hold out_valid/out_data stable until out_ready. On out_valid&&out_ready:
//     out_valid<=0; if addr==RAM_BYTES-1 -> IDLE, done=1; else addr+1 -> RD_REQ.
//   - Start pulses in non-IDLE states are ignored (not queued).
//   - Address arithmetic is ADDR_BITS wide; the final increment is never issued,
//     ram_addr returns to 0 on completion.
// TESTING
//   1. Reset: assert rst 2 cycles mid-LOAD -> all outputs at reset values next cycle,
//      busy=0, ram_lr_n=1, ram_ce_n=1.
//   2. Load 0x00..0x0F with in_valid held high -> exactly 16 ram_lr_n low pulses,
//      addr 0..15, 32 cycles, done pulse once, RAM[i]==i.
//   3. Dump after test 2, out_ready=1 -> out_data 0x00..0x0F in order, one
//      ram_ce_n pulse per byte, done once after byte 15.
//   4. Backpressure: dump with out_ready low 5 cycles on byte 3 -> out_data=0x03
//      stable, no further ram_ce_n pulse until accepted.
//   5. Gapped load: in_valid toggles every 3 cycles with data 0xA5^i -> RAM
//      contents correct, no write without handshake.
//   6. start_load and start_dump same cycle -> load performed, no dump; start_dump
//      during load ignored; lr_n/ce_n never simultaneously low (assertion).

Source files
------------

// File: rtl/ram_programmer.sv
// Program RAM load/dump controller.
// Streams a full image into the DFF program RAM or back out of it.
module ram_programmer #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_load_i,
    input  logic                 start_dump_i,
    input  logic                 in_valid_i,
    input  logic [7:0]           in_data_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    output logic [7:0]           out_data_o,
    input  logic                 out_ready_i,
    output logic [ADDR_BITS-1:0] ram_addr_o,
    output logic [7:0]           ram_wdata_o,
    input  logic [7:0]           ram_rdata_i,
    output logic                 ram_lr_n_o,
    output logic                 ram_ce_n_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RD_CAP,
        DUMP
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(RAM_BYTES - 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]           ram_wdata_q, ram_wdata_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 lr_n_q, lr_n_d;
    logic                 ce_n_q, ce_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state logic; every output is a registered function of the next state.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ram_wdata_d = ram_wdata_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_load_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end else if (start_dump_i) begin
                    state_d = RD_REQ;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                if (in_valid_i && in_ready_q) begin
                    ram_wdata_d = in_data_i;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (addr_q == LAST) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = LOAD;
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = RD_CAP;
            RD_CAP: begin
                out_data_d = ram_rdata_i;
                state_d    = DUMP;
            end
            DUMP: begin
                if (out_valid_q && out_ready_i) begin
                    if (addr_q == LAST) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ram_addr_d  = addr_d;
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == DUMP);
        lr_n_d      = (state_d != WRITE);
        ce_n_d      = (state_d != RD_REQ);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            lr_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            lr_n_q      <= lr_n_d;
            ce_n_q      <= ce_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_lr_n_o  = lr_n_q;
    assign ram_ce_n_o  = ce_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ram_programmer.sv
// Bench for ram_programmer: behavioural RAM, expected image model,
// load/dump/backpressure/collision scenarios.
module tb_ram_programmer;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_load, start_dump;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ram_lr_n, ram_ce_n, busy, done;

    always #5 clk = ~clk;

    ram_programmer #(.RAM_BYTES(N), .ADDR_BITS(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .start_load_i(start_load), .start_dump_i(start_dump),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .ram_lr_n_o(ram_lr_n), .ram_ce_n_o(ram_ce_n),
        .busy_o(busy), .done_o(done)
    );

    logic [7:0] ram_mem [N];
    logic [7:0] exp_mem [N];
    int         exp_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int lr_cnt, ce_cnt, done_cnt, busy_cnt;
    int both_cnt = 0;
    int lr_addrs[$];
    int ce_addrs[$];

    // Behavioural DFF RAM: write on lr_n low, registered read on ce_n low.
    always @(posedge clk) begin
        if (!ram_lr_n) ram_mem[ram_addr] <= ram_wdata;
        if (!ram_ce_n && ram_lr_n) ram_rdata <= ram_mem[ram_addr];
    end

    // Strobe/pulse monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (!ram_lr_n) begin
            lr_cnt++;
            lr_addrs.push_back(int'(ram_addr));
        end
        if (!ram_ce_n) begin
            ce_cnt++;
            ce_addrs.push_back(int'(ram_addr));
        end
        if (!ram_lr_n && !ram_ce_n) both_cnt++;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    function automatic bit seq_ok(input int q[$]);
        if (q.size() != N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (q[i] != i) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ram_diffs(input int upto);
        int d = 0;
        for (int i = 0; i < upto; i++)
            if (ram_mem[i] !== exp_mem[i]) d++;
        return d;
    endfunction

    task automatic clear_mon();
        @(negedge clk);
        #2;
        lr_cnt = 0; ce_cnt = 0; done_cnt = 0; busy_cnt = 0;
        lr_addrs.delete();
        ce_addrs.delete();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic run_load(input logic [7:0] img [N], input int mode,
                            input bit dump_same, input bit dump_mid);
        int  idx, cyc;
        bit  fin, v;
        clear_mon();
        start_load = 1'b1;
        start_dump = dump_same;
        @(negedge clk);
        start_load = 1'b0;
        start_dump = 1'b0;
        idx = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 400) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = ((cyc / 3) % 2) == 0;
                    default: v = 1'($urandom_range(0, 1));
                endcase
                in_valid   = v && (idx < N);
                in_data    = (in_valid) ? img[idx] : 8'($urandom);
                start_dump = dump_mid && (cyc == 5);
                if (in_valid && in_ready) begin
                    exp_mem[idx] = img[idx];
                    idx++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        start_dump = 1'b0;
        exp_valid = N;
        settle();
        n_checks++;
        if (!fin) $display("FAIL load_timeout: done not seen after %0d cycles", cyc);
        if (!fin) n_fail++;
        n_checks++;
        if (idx !== N) begin
            $display("FAIL load_handshakes: got %0d required %0d", idx, N);
            n_fail++;
        end
        n_checks++;
        if (lr_cnt !== N || !seq_ok(lr_addrs)) begin
            $display("FAIL load_strobes: lr pulses %0d addr_seq_ok %0d required %0d 1",
                     lr_cnt, seq_ok(lr_addrs), N);
            n_fail++;
        end
        n_checks++;
        if (done_cnt !== 1) begin
            $display("FAIL load_done: pulses %0d required 1", done_cnt);
            n_fail++;
        end
        n_checks++;
        if (ram_diffs(N) !== 0) begin
            $display("FAIL load_contents: %0d bytes differ, required 0", ram_diffs(N));
            n_fail++;
        end
        n_checks++;
        if (busy !== 1'b0 || ram_addr !== 4'h0) begin
            $display("FAIL load_idle: busy %0b addr %0h required 0 0", busy, ram_addr);
            n_fail++;
        end
    endtask

    task automatic run_dump(input int mode, input int stall_idx, input int stall_len);
        int k, cyc, st;
        bit fin;
        clear_mon();
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
        k = 0; cyc = 0; st = 0; fin = 1'b0;
        while (!fin && cyc < 800) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                if (out_valid && k == stall_idx && st < stall_len) begin
                    out_ready = 1'b0;
                    st++;
                    n_checks++;
                    if (out_data !== exp_mem[k] || ram_ce_n !== 1'b1 || out_valid !== 1'b1) begin
                        $display("FAIL dump_stall: data %0h ce_n %0b required %0h 1",
                                 out_data, ram_ce_n, exp_mem[k]);
                        n_fail++;
                    end
                end else begin
                    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                end
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (k >= N) begin
                        $display("FAIL dump_extra: byte %0d beyond image", k);
                        n_fail++;
                    end else if (out_data !== exp_mem[k]) begin
                        $display("FAIL dump_byte%0d: got %0h required %0h",
                                 k, out_data, exp_mem[k]);
                        n_fail++;
                    end
                    k++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        out_ready = 1'b0;
        settle();
        n_checks++;
        if (!fin || k !== N) begin
            $display("FAIL dump_count: done %0b bytes %0d required 1 %0d", fin, k, N);
            n_fail++;
        end
        n_checks++;
        if (ce_cnt !== N || !seq_ok(ce_addrs) || lr_cnt !== 0) begin
            $display("FAIL dump_strobes: ce %0d lr %0d addr_seq_ok %0d required %0d 0 1",
                     ce_cnt, lr_cnt, seq_ok(ce_addrs), N);
            n_fail++;
        end
        n_checks++;
        if (done_cnt !== 1) begin
            $display("FAIL dump_done: pulses %0d required 1", done_cnt);
            n_fail++;
        end
        n_checks++;
        if (stall_len > 0 && st !== stall_len) begin
            $display("FAIL dump_stall_len: stalled %0d required %0d", st, stall_len);
            n_fail++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({busy, done, in_ready, out_valid, ram_lr_n, ram_ce_n} !== 6'b000011) begin
            $display("FAIL %s_ctrl: got %b required 000011", tag,
                     {busy, done, in_ready, out_valid, ram_lr_n, ram_ce_n});
            n_fail++;
        end
        n_checks++;
        if ({ram_addr, ram_wdata, out_data} !== 20'h0) begin
            $display("FAIL %s_data: addr %0h wdata %0h out %0h required 0 0 0",
                     tag, ram_addr, ram_wdata, out_data);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        int idx;
        rst = 1'b1;
        start_load = 1'b0; start_dump = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_init");
        rst = 1'b0;
        @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            if (in_valid && in_ready) begin
                exp_mem[idx] = in_data;
                idx++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid1");
        @(negedge clk);
        check_reset_outputs("reset_mid2");
        rst = 1'b0;
        settle();
        n_checks++;
        if (idx == 0 || idx == N || ram_diffs(idx) !== 0) begin
            $display("FAIL reset_partial: bytes %0d diffs %0d required 1..15 0",
                     idx, ram_diffs(idx));
            n_fail++;
        end
    endtask

    task automatic test_load_seq();
        logic [7:0] img [N];
        for (int i = 0; i < N; i++) img[i] = 8'(i);
        run_load(img, 0, 1'b0, 1'b0);
        n_checks++;
        if (busy_cnt !== 2 * N) begin
            $display("FAIL load_cycles: busy %0d required %0d", busy_cnt, 2 * N);
            n_fail++;
        end
    endtask

    task automatic test_dump();
        run_dump(0, -1, 0);
    endtask

    task automatic test_backpressure();
        run_dump(0, 3, 5);
    endtask

    task automatic test_gapped_load();
        logic [7:0] img [N];
        for (int i = 0; i < N; i++) img[i] = 8'hA5 ^ 8'(i);
        run_load(img, 1, 1'b0, 1'b0);
        run_dump(0, -1, 0);
    endtask

    task automatic test_random();
        logic [7:0] img [N];
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom);
            run_load(img, 2, 1'b0, 1'b0);
            run_dump(1, int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_collision();
        logic [7:0] img [N];
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        run_load(img, 2, 1'b1, 1'b1);
        n_checks++;
        if (ce_cnt !== 0 || busy !== 1'b0) begin
            $display("FAIL collision_no_dump: ce pulses %0d busy %0b required 0 0",
                     ce_cnt, busy);
            n_fail++;
        end
        run_dump(0, -1, 0);
        n_checks++;
        if (both_cnt !== 0) begin
            $display("FAIL strobe_overlap: cycles %0d required 0", both_cnt);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_load_seq();
        test_dump();
        test_backpressure();
        test_gapped_load();
        test_random();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
